// File: rtl/lost_rx_decoder_pkg.sv
// Shared constants and state types for the LOST receive-side decoder.
package lost_rx_decoder_pkg;

  localparam logic [7:0] LOST_SYNC       = 8'hA5;
  localparam int         LOST_REC_BYTES  = 6;
  localparam int         LOST_TS_BITS    = 24;
  localparam int         LOST_OVS        = 16;
  localparam int         LOST_SYS_CLK_HZ = 100_000_000;
  localparam int         LOST_BAUD       = 115_200;
  // System clocks per 1/16-bit tick; 100 MHz / (115200 * 16) truncates to 54.
  localparam int         LOST_OVERSAMPLE_DIV = LOST_SYS_CLK_HZ / (LOST_BAUD * LOST_OVS);

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } uart_state_t;

  typedef enum logic [2:0] {
    P_HUNT,
    P_B1,
    P_B2,
    P_B3,
    P_B4,
    P_CSUM
  } parser_state_t;

endpackage

// File: rtl/lost_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, 16x oversample tick generator and
// a framing FSM. Emits one-clock byte_valid or frame_err pulses (registered).
module lost_uart_rx
  import lost_rx_decoder_pkg::*;
#(
  parameter int OVERSAMPLE_DIV = LOST_OVERSAMPLE_DIV
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       serialin,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam logic [15:0] DIV_LAST = 16'(OVERSAMPLE_DIV - 1);
  localparam logic [3:0]  MID_TICK = 4'(LOST_OVS / 2 - 1);
  localparam logic [3:0]  BIT_LAST = 4'(LOST_OVS - 1);

  logic        sync1_q, sync2_q, rx_prev_q;
  logic [15:0] cnt_q, cnt_d;
  uart_state_t state_q, state_d;
  logic [3:0]  tcnt_q, tcnt_d;
  logic [2:0]  bitn_q, bitn_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_data_q, byte_data_d;
  logic        byte_valid_q, byte_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        rx, tick, fall;

  assign rx         = sync2_q;
  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

  // Tick generation and framing FSM next-state; the tick counter is re-phased
  // on the start-bit edge so the 8th tick lands mid start bit.
  always_comb begin
    tick         = (cnt_q == DIV_LAST);
    fall         = rx_prev_q & ~rx;
    cnt_d        = tick ? 16'd0 : 16'(cnt_q + 16'd1);
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    bitn_d       = bitn_q;
    shift_d      = shift_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      U_IDLE: begin
        if (fall) begin
          cnt_d   = 16'd0;
          tcnt_d  = 4'd0;
          state_d = U_START;
        end
      end
      U_START: begin
        if (tick) begin
          if (tcnt_q == MID_TICK) begin
            tcnt_d = 4'd0;
            bitn_d = 3'd0;
            // A high line at mid start bit is a glitch: drop silently.
            state_d = rx ? U_IDLE : U_DATA;
          end else begin
            tcnt_d = 4'(tcnt_q + 4'd1);
          end
        end
      end
      U_DATA: begin
        if (tick) begin
          if (tcnt_q == BIT_LAST) begin
            tcnt_d  = 4'd0;
            shift_d = {rx, shift_q[7:1]};
            bitn_d  = 3'(bitn_q + 3'd1);
            if (bitn_q == 3'd7) state_d = U_STOP;
          end else begin
            tcnt_d = 4'(tcnt_q + 4'd1);
          end
        end
      end
      U_STOP: begin
        if (tick) begin
          if (tcnt_q == BIT_LAST) begin
            state_d = U_IDLE;
            if (rx) begin
              byte_valid_d = 1'b1;
              byte_data_d  = shift_q;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            tcnt_d = 4'(tcnt_q + 4'd1);
          end
        end
      end
      default: state_d = U_IDLE;
    endcase
  end

  // State registers; synchronizer and edge detector reset to the idle-high line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      cnt_q        <= 16'd0;
      state_q      <= U_IDLE;
      tcnt_q       <= 4'd0;
      bitn_q       <= 3'd0;
      shift_q      <= 8'd0;
      byte_data_q  <= 8'd0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync1_q      <= serialin;
      sync2_q      <= sync1_q;
      rx_prev_q    <= sync2_q;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      bitn_q       <= bitn_d;
      shift_q      <= shift_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

endmodule

// File: rtl/lost_rx_decoder.sv
// LOST record decoder: parses 6-byte records (SYNC, mask/level, ts x3, csum)
// from the UART byte stream and presents verified records on valid/ready.
//
// Handshake: rec_valid stays high with rec_mask/rec_level/rec_ts stable until
// the cycle where rec_valid && rec_ready; that cycle transfers the record and
// the register clears unless a new record loads in the same cycle. A record
// finishing while the register is full and not being drained is dropped and
// signalled with a one-clock err_overrun.
module lost_rx_decoder
  import lost_rx_decoder_pkg::*;
#(
  parameter int         OVERSAMPLE_DIV = LOST_OVERSAMPLE_DIV,
  parameter logic [7:0] SYNC_BYTE      = LOST_SYNC
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    serialin,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [3:0]              rec_mask,
  output logic [3:0]              rec_level,
  output logic [LOST_TS_BITS-1:0] rec_ts,
  output logic                    err_frame,
  output logic                    err_csum,
  output logic                    err_overrun
);

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_err;

  lost_uart_rx #(
    .OVERSAMPLE_DIV(OVERSAMPLE_DIV)
  ) u_uart (
    .clk       (clk),
    .rstn      (rstn),
    .serialin  (serialin),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  parser_state_t           pstate_q, pstate_d;
  logic [31:0]             buf_q, buf_d;    // {mask, level, ts}
  logic [7:0]              csum_q, csum_d;
  logic                    rec_valid_q, rec_valid_d;
  logic [3:0]              rec_mask_q, rec_mask_d;
  logic [3:0]              rec_level_q, rec_level_d;
  logic [LOST_TS_BITS-1:0] rec_ts_q, rec_ts_d;
  logic                    err_frame_q, err_frame_d;
  logic                    err_csum_q, err_csum_d;
  logic                    err_overrun_q, err_overrun_d;
  logic                    rec_ok, rec_bad, handshake;

  assign rec_valid   = rec_valid_q;
  assign rec_mask    = rec_mask_q;
  assign rec_level   = rec_level_q;
  assign rec_ts      = rec_ts_q;
  assign err_frame   = err_frame_q;
  assign err_csum    = err_csum_q;
  assign err_overrun = err_overrun_q;

  // Record parser, checksum check and single-entry output register.
  always_comb begin
    pstate_d      = pstate_q;
    buf_d         = buf_q;
    csum_d        = csum_q;
    rec_valid_d   = rec_valid_q;
    rec_mask_d    = rec_mask_q;
    rec_level_d   = rec_level_q;
    rec_ts_d      = rec_ts_q;
    err_frame_d   = frame_err;
    err_csum_d    = 1'b0;
    err_overrun_d = 1'b0;
    rec_ok        = 1'b0;
    rec_bad       = 1'b0;
    handshake     = rec_valid_q & rec_ready;

    if (frame_err) begin
      pstate_d = P_HUNT;
    end else if (byte_valid) begin
      case (pstate_q)
        P_HUNT: begin
          if (byte_data == SYNC_BYTE) begin
            pstate_d = P_B1;
            csum_d   = 8'd0;
          end
        end
        P_B1: begin
          buf_d[31:24] = byte_data;
          csum_d       = csum_q ^ byte_data;
          pstate_d     = P_B2;
        end
        P_B2: begin
          buf_d[23:16] = byte_data;
          csum_d       = csum_q ^ byte_data;
          pstate_d     = P_B3;
        end
        P_B3: begin
          buf_d[15:8] = byte_data;
          csum_d      = csum_q ^ byte_data;
          pstate_d    = P_B4;
        end
        P_B4: begin
          buf_d[7:0] = byte_data;
          csum_d     = csum_q ^ byte_data;
          pstate_d   = P_CSUM;
        end
        P_CSUM: begin
          pstate_d = P_HUNT;
          if (byte_data == csum_q) rec_ok = 1'b1;
          else                     rec_bad = 1'b1;
        end
        default: pstate_d = P_HUNT;
      endcase
    end

    if (handshake) begin
      rec_valid_d = 1'b0;
      rec_mask_d  = 4'd0;
      rec_level_d = 4'd0;
      rec_ts_d    = '0;
    end

    if (rec_ok) begin
      if (!rec_valid_q || rec_ready) begin
        rec_valid_d = 1'b1;
        rec_mask_d  = buf_q[31:28];
        rec_level_d = buf_q[27:24];
        rec_ts_d    = buf_q[23:0];
      end else begin
        err_overrun_d = 1'b1;
      end
    end

    err_csum_d = rec_bad;
  end

  // Parser and output registers; reset aborts any partial record.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pstate_q      <= P_HUNT;
      buf_q         <= 32'd0;
      csum_q        <= 8'd0;
      rec_valid_q   <= 1'b0;
      rec_mask_q    <= 4'd0;
      rec_level_q   <= 4'd0;
      rec_ts_q      <= '0;
      err_frame_q   <= 1'b0;
      err_csum_q    <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      pstate_q      <= pstate_d;
      buf_q         <= buf_d;
      csum_q        <= csum_d;
      rec_valid_q   <= rec_valid_d;
      rec_mask_q    <= rec_mask_d;
      rec_level_q   <= rec_level_d;
      rec_ts_q      <= rec_ts_d;
      err_frame_q   <= err_frame_d;
      err_csum_q    <= err_csum_d;
      err_overrun_q <= err_overrun_d;
    end
  end

endmodule
